// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the 4-bit CPU control sequencer: opcodes, FSM states,
// ALU/SP operation codes and the microcode control-word layout.
package cpu_seq_pkg;

    localparam logic [3:0] OpAdd      = 4'h0;
    localparam logic [3:0] OpSub      = 4'h1;
    localparam logic [3:0] OpInc      = 4'h2;
    localparam logic [3:0] OpNot      = 4'h3;
    localparam logic [3:0] OpRcl      = 4'h4;
    localparam logic [3:0] OpXchg     = 4'h5;
    localparam logic [3:0] OpTest     = 4'h6;
    localparam logic [3:0] OpOut      = 4'h7;
    localparam logic [3:0] OpMovBAddr = 4'h8;
    localparam logic [3:0] OpPush     = 4'h9;
    localparam logic [3:0] OpPop      = 4'hA;
    localparam logic [3:0] OpMovBByte = 4'hB;
    localparam logic [3:0] OpCall     = 4'hC;
    localparam logic [3:0] OpRet      = 4'hD;
    localparam logic [3:0] OpJmp      = 4'hE;
    localparam logic [3:0] OpHlt      = 4'hF;

    localparam logic [2:0] AluNone = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;
    localparam logic [2:0] AluInc  = 3'b011;
    localparam logic [2:0] AluNot  = 3'b100;
    localparam logic [2:0] AluRcl  = 3'b101;
    localparam logic [2:0] AluXor  = 3'b110;

    localparam int unsigned StepW = 3;

    typedef enum logic [2:0] {
        StIdle,
        StFetch1,
        StFetch2,
        StExec,
        StHalt
    } seq_state_e;

    typedef enum logic [1:0] {
        SpClear = 2'b00,
        SpHold  = 2'b01,
        SpPush  = 2'b10,
        SpPop   = 2'b11
    } sp_op_e;

    // Control word, MSB first: 15 datapath strobes, ALU op, SP op, latch controls.
    typedef struct packed {
        logic       cp;
        logic       ep;
        logic       ci;
        logic       lm;
        logic       we;
        logic       ce;
        logic       ed;
        logic       li;
        logic       la;
        logic       ea;
        logic       ealu;
        logic       lb;
        logic       eb;
        logic       esp;
        logic       lo;
        logic [2:0] alu_op;
        sp_op_e     sp_op;
        logic       opnd_oe;
        logic       opnd_ld;
    } ctrl_t;

    localparam int unsigned CtrlW = $bits(ctrl_t);

    function automatic logic [StepW-1:0] op_steps(input logic [3:0] op);
        case (op)
            OpAdd, OpSub, OpInc, OpNot, OpRcl: return 3'd2;
            OpXchg:                            return 3'd6;
            OpMovBAddr, OpPush:                return 3'd2;
            OpPop, OpRet:                      return 3'd3;
            OpCall:                            return 3'd4;
            default:                           return 3'd1;
        endcase
    endfunction

    function automatic logic [2:0] alu_code(input logic [3:0] op);
        case (op)
            OpAdd:   return AluAdd;
            OpSub:   return AluSub;
            OpInc:   return AluInc;
            OpNot:   return AluNot;
            OpRcl:   return AluRcl;
            default: return AluNone;
        endcase
    endfunction

endpackage

// File: rtl/seq_ucode_rom.sv
// Combinational microcode ROM: maps (opcode, EXEC step) to a control word and
// flags the final step of each instruction.
module seq_ucode_rom
    import cpu_seq_pkg::*;
(
    input  logic [3:0]       opcode,
    input  logic [StepW-1:0] step,
    output ctrl_t            ctrl,
    output logic             last
);

    always_comb begin
        ctrl       = '0;
        ctrl.sp_op = SpHold;
        case (opcode)
            OpAdd, OpSub, OpInc, OpNot, OpRcl: begin
                if (step == 3'd0) begin
                    ctrl.alu_op = alu_code(opcode);
                end else begin
                    ctrl.ealu = 1'b1;
                    ctrl.la   = 1'b1;
                end
            end
            // XOR swap: A^=B, B^=A, A^=B
            OpXchg: begin
                case (step)
                    3'd0, 3'd2, 3'd4: ctrl.alu_op = AluXor;
                    3'd3: begin
                        ctrl.ealu = 1'b1;
                        ctrl.lb   = 1'b1;
                    end
                    default: begin
                        ctrl.ealu = 1'b1;
                        ctrl.la   = 1'b1;
                    end
                endcase
            end
            OpTest: ctrl.alu_op = AluXor;
            OpOut: begin
                ctrl.ea = 1'b1;
                ctrl.lo = 1'b1;
            end
            OpMovBAddr: begin
                ctrl.ed = 1'b1;
                if (step == 3'd0) ctrl.lm = 1'b1;
                else              ctrl.lb = 1'b1;
            end
            OpMovBByte: begin
                ctrl.ed = 1'b1;
                ctrl.lb = 1'b1;
            end
            OpJmp: begin
                ctrl.ed = 1'b1;
                ctrl.ci = 1'b1;
            end
            OpPush: begin
                if (step == 3'd0) begin
                    ctrl.esp = 1'b1;
                    ctrl.lm  = 1'b1;
                end else begin
                    ctrl.we    = 1'b1;
                    ctrl.eb    = 1'b1;
                    ctrl.sp_op = SpPush;
                end
            end
            OpPop, OpRet: begin
                case (step)
                    3'd0: ctrl.sp_op = SpPop;
                    3'd1: begin
                        ctrl.esp = 1'b1;
                        ctrl.lm  = 1'b1;
                    end
                    default: begin
                        ctrl.ed = 1'b1;
                        if (opcode == OpRet) ctrl.ci = 1'b1;
                        else                 ctrl.lb = 1'b1;
                    end
                endcase
            end
            OpCall: begin
                case (step)
                    3'd0: begin
                        ctrl.ed      = 1'b1;
                        ctrl.opnd_ld = 1'b1;
                    end
                    3'd1: begin
                        ctrl.esp = 1'b1;
                        ctrl.lm  = 1'b1;
                    end
                    3'd2: begin
                        ctrl.ep    = 1'b1;
                        ctrl.we    = 1'b1;
                        ctrl.sp_op = SpPush;
                    end
                    default: begin
                        ctrl.opnd_oe = 1'b1;
                        ctrl.ci      = 1'b1;
                    end
                endcase
            end
            default: ;
        endcase
        // HLT never completes; the sequencer diverts it to HALT instead.
        last = (opcode != OpHlt) && (step + 3'd1 >= op_steps(opcode));
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/execute control sequencer with run/step/halt control, a Moore strobe
// decode of registered state, and the CALL operand latch.
module cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter bit RUN_ON_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       step,
    input  logic [3:0] ir_opcode,
    input  logic [3:0] bus_in,
    output logic       cp,
    output logic       ep,
    output logic       ci,
    output logic       lm,
    output logic       we,
    output logic       ce,
    output logic       ed,
    output logic       li,
    output logic       la,
    output logic       ea,
    output logic       ealu,
    output logic       lb,
    output logic       eb,
    output logic       esp,
    output logic       lo,
    output logic [2:0] alu_op,
    output logic [1:0] sp_op,
    output logic [3:0] opnd_out,
    output logic       opnd_oe,
    output logic       busy,
    output logic       halted,
    output logic       instr_done,
    output logic [3:0] t_state
);

    seq_state_e       state_q, state_d;
    logic [StepW-1:0] step_q, step_d;
    logic [3:0]       opnd_q, opnd_d;
    ctrl_t            rom_ctrl;
    logic             rom_last;
    ctrl_t            c;
    logic             run_eff;
    logic             is_hlt;

    assign run_eff = run | RUN_ON_RESET;
    assign is_hlt  = (ir_opcode == OpHlt) && (step_q == 3'd0);

    seq_ucode_rom u_rom (
        .opcode (ir_opcode),
        .step   (step_q),
        .ctrl   (rom_ctrl),
        .last   (rom_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            opnd_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            opnd_q  <= opnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        opnd_d  = c.opnd_ld ? bus_in : opnd_q;
        case (state_q)
            StIdle: begin
                if (run_eff || step) state_d = StFetch1;
            end
            StFetch1: state_d = StFetch2;
            StFetch2: begin
                state_d = StExec;
                step_d  = '0;
            end
            StExec: begin
                if (is_hlt) begin
                    state_d = StHalt;
                end else if (rom_last) begin
                    // run is sampled only at instruction boundaries
                    state_d = run_eff ? StFetch1 : StIdle;
                    step_d  = '0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            StHalt:  state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        c          = '0;
        c.sp_op    = SpHold;
        instr_done = 1'b0;
        busy       = 1'b0;
        halted     = 1'b0;
        t_state    = 4'd0;
        case (state_q)
            StFetch1: begin
                c.ep = 1'b1;
                c.lm = 1'b1;
                busy = 1'b1;
            end
            StFetch2: begin
                c.cp    = 1'b1;
                c.ce    = 1'b1;
                c.li    = 1'b1;
                busy    = 1'b1;
                t_state = 4'd1;
            end
            StExec: begin
                busy    = 1'b1;
                t_state = 4'd2 + {1'b0, step_q};
                if (!is_hlt) begin
                    c          = rom_ctrl;
                    instr_done = rom_last;
                end
            end
            StHalt:  halted = 1'b1;
            default: ;
        endcase
    end

    assign cp       = c.cp;
    assign ep       = c.ep;
    assign ci       = c.ci;
    assign lm       = c.lm;
    assign we       = c.we;
    assign ce       = c.ce;
    assign ed       = c.ed;
    assign li       = c.li;
    assign la       = c.la;
    assign ea       = c.ea;
    assign ealu     = c.ealu;
    assign lb       = c.lb;
    assign eb       = c.eb;
    assign esp      = c.esp;
    assign lo       = c.lo;
    assign alu_op   = c.alu_op;
    // SP is held clear for as long as reset is asserted
    assign sp_op    = rst_n ? c.sp_op : SpClear;
    assign opnd_out = opnd_q;
    assign opnd_oe  = c.opnd_oe;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a directed vector table, hand-written HLT and reset
// sequences, then random run/step/reset traffic against a queue-based model.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [3:0] ir_opcode = 4'h0;
    logic [3:0] bus_in = 4'h0;
    logic       cp, ep, ci, lm, we, ce, ed, li, la, ea, ealu, lb, eb, esp, lo;
    logic [2:0] alu_op;
    logic [1:0] sp_op;
    logic [3:0] opnd_out;
    logic       opnd_oe, busy, halted, instr_done;
    logic [3:0] t_state;

    cpu_sequencer #(.RUN_ON_RESET(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .step(step), .ir_opcode(ir_opcode),
        .bus_in(bus_in), .cp(cp), .ep(ep), .ci(ci), .lm(lm), .we(we), .ce(ce), .ed(ed),
        .li(li), .la(la), .ea(ea), .ealu(ealu), .lb(lb), .eb(eb), .esp(esp), .lo(lo),
        .alu_op(alu_op), .sp_op(sp_op), .opnd_out(opnd_out), .opnd_oe(opnd_oe),
        .busy(busy), .halted(halted), .instr_done(instr_done), .t_state(t_state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [14:0] strb;
        logic [2:0]  alu;
        logic [1:0]  sp;
        logic        oe, bsy, hlt, done;
        logic [3:0]  ts;
    } obs_t;

    localparam logic [14:0] CP = 15'h4000, EP = 15'h2000, CI = 15'h1000, LM = 15'h0800;
    localparam logic [14:0] WE = 15'h0400, CE = 15'h0200, ED = 15'h0100, LI = 15'h0080;
    localparam logic [14:0] LA = 15'h0040, EA = 15'h0020, EALU = 15'h0010, LB = 15'h0008;
    localparam logic [14:0] EB = 15'h0004, ESP = 15'h0002, LO = 15'h0001, NS = 15'h0000;

    obs_t got;
    assign got = {cp, ep, ci, lm, we, ce, ed, li, la, ea, ealu, lb, eb, esp, lo,
                  alu_op, sp_op, opnd_oe, busy, halted, instr_done, t_state};

    function automatic obs_t mk(input logic [14:0] s, input logic [2:0] a, input logic [1:0] sp,
                                input logic oe, input logic bsy, input logic hlt,
                                input logic done, input logic [3:0] ts);
        obs_t o;
        o = '{strb: s, alu: a, sp: sp, oe: oe, bsy: bsy, hlt: hlt, done: done, ts: ts};
        return o;
    endfunction

    function automatic obs_t ex(input logic [14:0] s, input logic [2:0] a, input logic [1:0] sp,
                                input logic oe, input int k, input logic done);
        return mk(s, a, sp, oe, 1'b1, 1'b0, done, 4'(2 + k));
    endfunction

    obs_t o_idle, o_rst, o_halt, o_f1, o_f2;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input obs_t e, input logic [3:0] eo);
        n_vec++;
        if (got !== e || opnd_out !== eo) begin
            n_err++;
            $display("FAIL %s @%0t: got outputs=%h opnd=%h, required outputs=%h opnd=%h",
                     name, $time, got, opnd_out, e, eo);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Instruction table: step counts and per-step rows.
    function automatic int n_steps(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9: return 2;
            4'd5:                                     return 6;
            4'd10, 4'd13:                             return 3;
            4'd12:                                    return 4;
            default:                                  return 1;
        endcase
    endfunction

    function automatic obs_t exec_row(input logic [3:0] op, input int k);
        logic [14:0] s;
        logic [2:0]  a;
        logic [1:0]  sp;
        logic        oe;
        s = NS; a = 3'b000; sp = 2'b01; oe = 1'b0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4: if (k == 0) a = op[2:0] + 3'd1; else s = EALU | LA;
            4'd5:  if (k % 2 == 0) a = 3'b110; else s = (k == 3) ? (EALU | LB) : (EALU | LA);
            4'd6:  a = 3'b110;
            4'd7:  s = EA | LO;
            4'd8:  s = (k == 0) ? (ED | LM) : (ED | LB);
            4'd9:  if (k == 0) s = ESP | LM; else begin s = WE | EB; sp = 2'b10; end
            4'd10: if (k == 0) sp = 2'b11; else s = (k == 1) ? (ESP | LM) : (ED | LB);
            4'd11: s = ED | LB;
            4'd12: case (k)
                       0:       s = ED;
                       1:       s = ESP | LM;
                       2:       begin s = EP | WE; sp = 2'b10; end
                       default: begin s = CI; oe = 1'b1; end
                   endcase
            4'd13: if (k == 0) sp = 2'b11; else s = (k == 1) ? (ESP | LM) : (ED | CI);
            4'd14: s = ED | CI;
            default: ;
        endcase
        return ex(s, a, sp, oe, k, k == n_steps(op) - 1);
    endfunction

    // Reference model: queue of the cycles still to come for the current instruction.
    obs_t       mq[$];
    logic       mcap[$];
    obs_t       m_cur;
    logic       m_cap;
    int         m_phase;   // 0 idle, 1 running, 2 halted
    logic [3:0] m_opnd;
    logic [3:0] m_op;
    logic       m_started;

    task automatic model_reset();
        mq.delete(); mcap.delete();
        m_phase = 0; m_opnd = 4'h0; m_cap = 1'b0; m_cur = o_rst;
    endtask

    task automatic model_start(input logic [3:0] op);
        mq.delete(); mcap.delete();
        mq.push_back(o_f1); mcap.push_back(1'b0);
        mq.push_back(o_f2); mcap.push_back(1'b0);
        if (op == 4'hF) begin
            mq.push_back(ex(NS, 3'b000, 2'b01, 1'b0, 0, 1'b0)); mcap.push_back(1'b0);
            mq.push_back(o_halt);                              mcap.push_back(1'b0);
        end else begin
            for (int k = 0; k < n_steps(op); k++) begin
                mq.push_back(exec_row(op, k));
                mcap.push_back(op == 4'hC && k == 0);
            end
        end
    endtask

    task automatic model_edge();
        m_started = 1'b0;
        if (m_cap) m_opnd = bus_in;
        if (m_phase == 2) begin
            m_cur = o_halt; m_cap = 1'b0;
        end else if (mq.size() > 0) begin
            m_cur = mq.pop_front(); m_cap = mcap.pop_front();
            if (m_cur.hlt) m_phase = 2;
        end else if (m_phase == 0 ? (run || step) : run) begin
            m_op = 4'($urandom_range(0, 15));
            model_start(m_op);
            m_cur = mq.pop_front(); m_cap = mcap.pop_front();
            m_phase = 1; m_started = 1'b1;
        end else begin
            m_cur = o_idle; m_cap = 1'b0; m_phase = 0;
        end
    endtask

    typedef struct {
        logic       run, step;
        logic [3:0] op, bus;
        obs_t       e;
        logic [3:0] eo;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic s, input logic [3:0] op, input logic [3:0] bus,
                       input obs_t e, input logic [3:0] eo);
        vec_t v;
        v.run = r; v.step = s; v.op = op; v.bus = bus; v.e = e; v.eo = eo;
        tv.push_back(v);
    endtask

    initial begin
        o_idle = mk(NS, 3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        o_rst  = mk(NS, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        o_halt = mk(NS, 3'b000, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        o_f1   = mk(EP | LM, 3'b000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        o_f2   = mk(CP | CE | LI, 3'b000, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);

        // ADD twice (run dropped during the second), stepped PUSH, stepped CALL
        add(1, 0, 4'h0, 4'h0, o_f1, 4'h0);
        add(1, 0, 4'h0, 4'h0, o_f2, 4'h0);
        add(1, 0, 4'h0, 4'h0, ex(NS, 3'b001, 2'b01, 0, 0, 0), 4'h0);
        add(0, 0, 4'h0, 4'h0, ex(EALU | LA, 3'b000, 2'b01, 0, 1, 1), 4'h0);
        add(1, 0, 4'h0, 4'h0, o_f1, 4'h0);
        add(0, 0, 4'h0, 4'h0, o_f2, 4'h0);
        add(0, 0, 4'h0, 4'h0, ex(NS, 3'b001, 2'b01, 0, 0, 0), 4'h0);
        add(0, 0, 4'h0, 4'h0, ex(EALU | LA, 3'b000, 2'b01, 0, 1, 1), 4'h0);
        add(0, 0, 4'h0, 4'h0, o_idle, 4'h0);
        add(0, 1, 4'h9, 4'h0, o_f1, 4'h0);
        add(0, 0, 4'h9, 4'h0, o_f2, 4'h0);
        add(0, 1, 4'h9, 4'h0, ex(ESP | LM, 3'b000, 2'b01, 0, 0, 0), 4'h0);
        add(0, 0, 4'h9, 4'h0, ex(WE | EB, 3'b000, 2'b10, 0, 1, 1), 4'h0);
        add(0, 1, 4'h9, 4'h0, o_idle, 4'h0);
        add(0, 0, 4'h9, 4'h0, o_idle, 4'h0);
        add(0, 1, 4'hC, 4'h0, o_f1, 4'h0);
        add(0, 0, 4'hC, 4'h0, o_f2, 4'h0);
        add(0, 0, 4'hC, 4'h5, ex(ED, 3'b000, 2'b01, 0, 0, 0), 4'h0);
        add(0, 0, 4'hC, 4'hA, ex(ESP | LM, 3'b000, 2'b01, 0, 1, 0), 4'hA);
        add(0, 0, 4'hC, 4'h3, ex(EP | WE, 3'b000, 2'b10, 0, 2, 0), 4'hA);
        add(0, 0, 4'hC, 4'h6, ex(CI, 3'b000, 2'b01, 1, 3, 1), 4'hA);
        add(0, 0, 4'hC, 4'h6, o_idle, 4'hA);

        // Reset held with run high, then released mid-cycle
        rst_n = 1'b0; run = 1'b1; ir_opcode = 4'h0;
        repeat (3) @(posedge clk);
        #1 chk("reset_state", o_rst, 4'h0);
        #2 rst_n = 1'b1;
        #1 chk("reset_release", o_idle, 4'h0);

        foreach (tv[i]) begin
            run = tv[i].run; step = tv[i].step; ir_opcode = tv[i].op; bus_in = tv[i].bus;
            tick();
            chk($sformatf("vec[%0d]", i), tv[i].e, tv[i].eo);
        end

        // HLT: three clocks to HALT, then deaf to run/step until reset
        run = 1'b1; step = 1'b0; ir_opcode = 4'hF;
        tick(); chk("hlt_t1", o_f1, 4'hA);
        tick(); chk("hlt_t2", o_f2, 4'hA);
        run = 1'b0;
        tick(); chk("hlt_e0", ex(NS, 3'b000, 2'b01, 0, 0, 0), 4'hA);
        tick(); chk("hlt_halted", o_halt, 4'hA);
        step = 1'b1;
        tick(); chk("hlt_step_ignored", o_halt, 4'hA);
        step = 1'b0; run = 1'b1;
        tick(); chk("hlt_run_ignored", o_halt, 4'hA);
        rst_n = 1'b0;
        #1 chk("hlt_reset", o_rst, 4'h0);
        #1 rst_n = 1'b1; run = 1'b0;
        tick(); chk("hlt_after_reset", o_idle, 4'h0);

        // XCHG aborted by reset at step 3
        run = 1'b1; ir_opcode = 4'h5;
        tick(); chk("xchg_t1", o_f1, 4'h0);
        tick(); chk("xchg_t2", o_f2, 4'h0);
        tick(); chk("xchg_e0", ex(NS, 3'b110, 2'b01, 0, 0, 0), 4'h0);
        tick(); chk("xchg_e1", ex(EALU | LA, 3'b000, 2'b01, 0, 1, 0), 4'h0);
        tick(); chk("xchg_e2", ex(NS, 3'b110, 2'b01, 0, 2, 0), 4'h0);
        tick(); chk("xchg_e3", ex(EALU | LB, 3'b000, 2'b01, 0, 3, 0), 4'h0);
        rst_n = 1'b0;
        #1 chk("xchg_abort", o_rst, 4'h0);
        #1 rst_n = 1'b1;
        tick(); chk("xchg_restart", o_f1, 4'h0);

        // Random traffic against the model, starting from a clean reset
        rst_n = 1'b0; run = 1'b0; step = 1'b0;
        model_reset();
        #2 rst_n = 1'b1;
        m_cur = o_idle;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            run    = ($urandom_range(0, 9) < 6);
            step   = ($urandom_range(0, 5) == 0);
            bus_in = 4'($urandom);
            @(posedge clk);
            model_edge();
            #1;
            chk("random", m_cur, m_opnd);
            if (m_started) ir_opcode = m_op;
            if ($urandom_range(0, (m_phase == 2) ? 5 : 60) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1 chk("random_reset", m_cur, m_opnd);
                #1 rst_n = 1'b1;
                m_cur = o_idle;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
